// File: rtl/dmem_access_unit.sv
// dmem_access_unit: one-at-a-time load/store responder between X stage and data memory.
// Builds byte masks and lane-shifted store data, aligns/extends loads, stalls until done.
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        x_re,
    input  logic        x_we,
    input  logic [2:0]  x_funct3,
    input  logic [31:0] x_addr,
    input  logic [31:0] x_wdata,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic [3:0]  mem_req_wmask,
    output logic [31:0] mem_req_wdata,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data
);
    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
    state_t state, state_n;
    logic x_req, illegal, is_load, err_mis, err_to, timeout, finish_ok;
    logic [1:0] lane;
    logic [2:0] f3;
    logic [CNT_W-1:0] cnt, cnt_inc;
    logic [3:0] mask;
    logic [31:0] sh_wdata, sh_rdata, ld_data;

    assign x_req = x_re | x_we;
    assign illegal = (x_re & x_we) | (x_funct3[1:0] == 2'b01 & x_addr[0])
                   | (x_funct3[1] & x_addr[1:0] != 2'b00);
    assign mask = x_funct3[1:0] == 2'b00 ? 4'b0001 << x_addr[1:0]
                : x_funct3[1:0] == 2'b01 ? 4'b0011 << {x_addr[1], 1'b0} : 4'b1111;
    assign sh_wdata = x_wdata << {x_addr[1:0], 3'b000};
    assign sh_rdata = mem_resp_data >> {lane, 3'b000};
    assign ld_data = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh_rdata[7]}}, sh_rdata[7:0]}
                   : f3[1:0] == 2'b01 ? {{16{~f3[2] & sh_rdata[15]}}, sh_rdata[15:0]} : sh_rdata;
    // Counter saturates at the limit so a load accepted on the last allowed cycle still times out in RESP
    assign cnt_inc = cnt + CNT_W'(1);
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    assign finish_ok = (state == REQ & mem_req_ready) | (state == RESP & mem_resp_valid);

    assign stall = (state == IDLE & x_req) | state == REQ | state == RESP;
    assign mem_req_valid = state == REQ;
    assign wb_valid = state == DONE;
    assign err_misalign = wb_valid & err_mis;
    assign err_timeout = wb_valid & err_to;

    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        case (state)
            IDLE: state_n = x_req ? (illegal ? DONE : REQ) : IDLE;
            REQ:  state_n = mem_req_ready ? (is_load ? RESP : DONE) : (timeout ? DONE : REQ);
            RESP: state_n = (mem_resp_valid | timeout) ? DONE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_load <= 1'b0;
            f3 <= 3'b000;
            lane <= 2'b00;
            err_mis <= 1'b0;
            err_to <= 1'b0;
            cnt <= '0;
            wb_data <= 32'h0;
            mem_req_addr <= 32'h0;
            mem_req_wmask <= 4'h0;
            mem_req_wdata <= 32'h0;
        end else if (state == IDLE) begin
            if (x_req) begin
                is_load <= x_re;
                f3 <= x_funct3;
                lane <= x_addr[1:0];
                err_mis <= illegal;
                err_to <= 1'b0;
                cnt <= '0;
                wb_data <= 32'h0;
                if (!illegal) begin
                    mem_req_addr <= {x_addr[31:2], 2'b00};
                    mem_req_wmask <= x_we ? mask : 4'h0;
                    mem_req_wdata <= x_we ? sh_wdata : 32'h0;
                end
            end
        end else if (state == REQ || state == RESP) begin
            cnt <= timeout ? cnt : cnt_inc;
            err_to <= ~finish_ok & timeout;
            if (state == RESP && mem_resp_valid) wb_data <= ld_data;
        end
    end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: directed tests on a default instance and a TIMEOUT_CYCLES=4 instance.
module tb_dmem_access_unit;
    logic clk = 1'b0, reset = 1'b1;
    logic x_re = 1'b0, x_we = 1'b0;
    logic [2:0] x_funct3 = 3'b000;
    logic [31:0] x_addr = 32'h0, x_wdata = 32'h0;
    logic mem_req_ready = 1'b0, mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic stall, wb_valid, err_misalign, err_timeout, mem_req_valid;
    logic [31:0] wb_data, mem_req_addr, mem_req_wdata;
    logic [3:0] mem_req_wmask;
    logic t_stall, t_wb_valid, t_err_misalign, t_err_timeout, t_mem_req_valid;
    logic [31:0] t_wb_data, t_mem_req_addr, t_mem_req_wdata;
    logic [3:0] t_mem_req_wmask;
    int passed = 0, total = 0;

    always #5 clk = ~clk;

    dmem_access_unit dut (
        .clk(clk), .reset(reset), .x_re(x_re), .x_we(x_we), .x_funct3(x_funct3),
        .x_addr(x_addr), .x_wdata(x_wdata), .stall(stall), .wb_valid(wb_valid),
        .wb_data(wb_data), .err_misalign(err_misalign), .err_timeout(err_timeout),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wmask(mem_req_wmask),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    dmem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut_t (
        .clk(clk), .reset(reset), .x_re(x_re), .x_we(x_we), .x_funct3(x_funct3),
        .x_addr(x_addr), .x_wdata(x_wdata), .stall(t_stall), .wb_valid(t_wb_valid),
        .wb_data(t_wb_data), .err_misalign(t_err_misalign), .err_timeout(t_err_timeout),
        .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(t_mem_req_addr), .mem_req_wmask(t_mem_req_wmask),
        .mem_req_wdata(t_mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_data(mem_resp_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic re, input logic we, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d);
        x_re = re; x_we = we; x_funct3 = f; x_addr = a; x_wdata = d;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got %b exp 0", wb_valid); else passed++;
        total++; if (mem_req_valid !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", mem_req_valid); else passed++;
        total++; if (wb_data !== 32'h0) $display("FAIL rst_wb_data got %h exp 00000000", wb_data); else passed++;
        total++; if (mem_req_wmask !== 4'h0) $display("FAIL rst_wmask got %h exp 0", mem_req_wmask); else passed++;
        reset = 1'b0;
        step();
    endtask

    task automatic test_store();
        mem_req_ready = 1'b1;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
        total++; if (stall !== 1'b1) $display("FAIL sw_idle_stall got %b exp 1", stall); else passed++;
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        total++; if (mem_req_valid !== 1'b1) $display("FAIL sw_req_valid got %b exp 1", mem_req_valid); else passed++;
        total++; if (mem_req_wmask !== 4'b1111) $display("FAIL sw_wmask got %b exp 1111", mem_req_wmask); else passed++;
        total++; if (mem_req_wdata !== 32'hDEAD_BEEF) $display("FAIL sw_wdata got %h exp deadbeef", mem_req_wdata); else passed++;
        total++; if (wb_valid !== 1'b0) $display("FAIL sw_early_wb got %b exp 0", wb_valid); else passed++;
        step();
        total++; if (wb_valid !== 1'b1) $display("FAIL sw_wb_valid got %b exp 1", wb_valid); else passed++;
        total++; if (stall !== 1'b0) $display("FAIL sw_done_stall got %b exp 0", stall); else passed++;
        step();
        total++; if (wb_valid !== 1'b0) $display("FAIL sw_wb_pulse got %b exp 0", wb_valid); else passed++;
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0000_00AB);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        total++; if (mem_req_wmask !== 4'b1000) $display("FAIL sb_wmask got %b exp 1000", mem_req_wmask); else passed++;
        total++; if (mem_req_wdata[31:24] !== 8'hAB) $display("FAIL sb_wdata got %h exp ab", mem_req_wdata[31:24]); else passed++;
        total++; if (mem_req_addr !== 32'h0000_0100) $display("FAIL sb_addr got %h exp 00000100", mem_req_addr); else passed++;
        step(); step();
    endtask

    task automatic load_run(input logic [2:0] f, input logic [31:0] a, input logic [31:0] resp, input logic [31:0] exp, input string name);
        mem_req_ready = 1'b1;
        issue(1'b1, 1'b0, f, a, 32'h0);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        total++; if (mem_req_wmask !== 4'h0) $display("FAIL %s_wmask got %h exp 0", name, mem_req_wmask); else passed++;
        step();
        mem_resp_valid = 1'b1; mem_resp_data = resp;
        step();
        mem_resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b1) $display("FAIL %s_wb_valid got %b exp 1", name, wb_valid); else passed++;
        total++; if (wb_data !== exp) $display("FAIL %s_data got %h exp %h", name, wb_data, exp); else passed++;
        step();
    endtask

    task automatic test_loads();
        load_run(3'b000, 32'h0000_0101, 32'h0000_80FF, 32'hFFFF_FF80, "lb");
        load_run(3'b100, 32'h0000_0101, 32'h0000_80FF, 32'h0000_0080, "lbu");
        load_run(3'b001, 32'h0000_0102, 32'h8001_0000, 32'hFFFF_8001, "lh");
        load_run(3'b101, 32'h0000_0102, 32'h8001_0000, 32'h0000_8001, "lhu");
    endtask

    task automatic test_misalign();
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        total++; if (wb_valid !== 1'b1) $display("FAIL lw_mis_wb got %b exp 1", wb_valid); else passed++;
        total++; if (err_misalign !== 1'b1) $display("FAIL lw_mis_err got %b exp 1", err_misalign); else passed++;
        total++; if (mem_req_valid !== 1'b0) $display("FAIL lw_mis_req got %b exp 0", mem_req_valid); else passed++;
        step();
        total++; if (err_misalign !== 1'b0) $display("FAIL lw_mis_pulse got %b exp 0", err_misalign); else passed++;
        issue(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h0);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        total++; if (err_misalign !== 1'b1) $display("FAIL rewe_err got %b exp 1", err_misalign); else passed++;
        step();
    endtask

    task automatic test_wait_states();
        mem_req_ready = 1'b0;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0000_0200 || stall !== 1'b1)
                $display("FAIL ws_req_hold got v=%b a=%h s=%b exp v=1 a=00000200 s=1", mem_req_valid, mem_req_addr, stall);
            else passed++;
            step();
        end
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++; if (stall !== 1'b1 || wb_valid !== 1'b0)
                $display("FAIL ws_resp_wait got s=%b wb=%b exp s=1 wb=0", stall, wb_valid);
            else passed++;
            step();
        end
        mem_resp_valid = 1'b1; mem_resp_data = 32'h1234_5678;
        step();
        mem_resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_data !== 32'h1234_5678)
            $display("FAIL ws_done got wb=%b d=%h exp wb=1 d=12345678", wb_valid, wb_data);
        else passed++;
        step();
    endtask

    task automatic test_timeout_and_reset();
        mem_req_ready = 1'b1;
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        step();
        issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step(); step(); step();
        total++; if (t_wb_valid !== 1'b0 || t_stall !== 1'b1)
            $display("FAIL to_early got wb=%b s=%b exp wb=0 s=1", t_wb_valid, t_stall);
        else passed++;
        step();
        total++; if (t_wb_valid !== 1'b1) $display("FAIL to_wb_valid got %b exp 1", t_wb_valid); else passed++;
        total++; if (t_err_timeout !== 1'b1) $display("FAIL to_err got %b exp 1", t_err_timeout); else passed++;
        total++; if (t_wb_data !== 32'h0) $display("FAIL to_data got %h exp 00000000", t_wb_data); else passed++;
        total++; if (stall !== 1'b1 || err_timeout !== 1'b0)
            $display("FAIL to_default_waits got s=%b e=%b exp s=1 e=0", stall, err_timeout);
        else passed++;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++; if (stall !== 1'b0 || wb_valid !== 1'b0 || mem_req_valid !== 1'b0)
            $display("FAIL rst_mid got s=%b wb=%b v=%b exp 0 0 0", stall, wb_valid, mem_req_valid);
        else passed++;
        mem_resp_valid = 1'b1; mem_resp_data = 32'hFFFF_FFFF;
        step();
        mem_resp_valid = 1'b0;
        total++; if (wb_valid !== 1'b0 || stall !== 1'b0)
            $display("FAIL rst_resp_ignored got wb=%b s=%b exp 0 0", wb_valid, stall);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_misalign();
        test_wait_states();
        test_timeout_and_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
